branch_resolution_unit: RTL and testbench
=========================================

Name: branch_resolution_unit

Overview:
- Drives the update and rollback side of the history predictor.
- Issues a speculative history push for every branch predicted at IF.
- Tracks the speculative entries of the ID and EX slots, and compares the EX-stage actual outcome with the prediction.
- On a mispredict: rolls back the ID/EX entries, redirects fetch, then re-pushes the corrected outcome one cycle later.

Parameters:
- PC_WIDTH, 32, width of the PC and target buses.
- PERF_CNT_WIDTH, 32, width of the optional statistics counters.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- PL_stall  input  1  pipeline stall; ID/EX slots hold
- if_is_branch  input  1  IF instruction is a conditional branch (predecoded)
- if_pred_taken  input  1  predicted direction (HP_count MSB)
- ex_resolve_en  input  1  EX holds a conditional branch with a valid outcome
- ex_taken  input  1  actual direction in EX
- pc_ex  input  PC_WIDTH  PC of the EX instruction
- ex_target  input  PC_WIDTH  taken-target of the EX branch
- corrected_en  output  1  push a history bit and update the counter
- corrected_result  output  1  bit to push
- rollback_en_id  output  1  undo the ID-slot speculative entry
- rollback_en_ex  output  1  undo the EX-slot entry and correct its counter
- mispredict  output  1  flush IF/ID and redirect fetch
- redirect_pc  output  PC_WIDTH  fetch target when mispredict=1
- fix_stall  output  1  front-end hold during the FIX state
- perf_branches  output  PERF_CNT_WIDTH  only with BRU_PERF_COUNTER_EN
- perf_mispredicts  output  PERF_CNT_WIDTH  only with BRU_PERF_COUNTER_EN

Behaviour:
- Reset: asynchronous, active-low.
  - Cleared on reset: br_id, pred_id, br_ex, pred_ex, fix_result, the perf counters; state goes to IDLE.
  - All outputs are 0 during and right after reset. redirect_pc = 0.
- Slot state: br_x = slot x holds a branch that pushed history; pred_x = its pushed bit.
- IF push: if_fire = if_is_branch & !PL_stall & !mispredict & state==IDLE.
  - corrected_en = if_fire, corrected_result = if_pred_taken. Combinational, same cycle.
- Resolve: res = ex_resolve_en & br_ex & !PL_stall.
  - mispredict = res & (ex_taken != pred_ex). Combinational.
  - An ex_resolve_en without br_ex is ignored.
- On mispredict, in the same cycle:
  - rollback_en_ex = 1; rollback_en_id = br_id.
  - redirect_pc = ex_taken ? ex_target : pc_ex + 4, modulo 2^PC_WIDTH.
  - corrected_en is suppressed.
  - Next edge: br_id, br_ex cleared; fix_result <= ex_taken; state -> FIX.
- FIX state, one cycle:
  - corrected_en = 1, corrected_result = fix_result. This pushes the true outcome and the predictor increments/decrements the counter.
  - fix_stall = 1; IF push is suppressed.
  - Next edge: state -> IDLE regardless of PL_stall.
- Correct prediction: no rollback and no push; history already holds the right bit.
- Slot advance when !PL_stall & !mispredict:
  - br_ex <= br_id, pred_ex <= pred_id.
  - br_id <= if_fire, pred_id <= if_pred_taken.
- PL_stall = 1: slots hold, no resolve, no IF push. The FIX state still completes.
- A mispredict cannot occur in FIX: br_ex = 0 there.
- Reset mid-FIX returns to IDLE without emitting the push.

Optional Feature:
- Macro: BRU_PERF_COUNTER_EN.
- Defined:
  - perf_branches increments on each res.
  - perf_mispredicts increments on each mispredict.
  - Both saturate at all-ones.
- Undefined: both ports tied to 0, no counter flops.

Decomposition:
- Package branch_res_pkg holds:
  - state enum {IDLE, FIX}
  - PC_STEP = 4
  - localparam for saturate-all-ones
- One sub-module, sat_event_counter (WIDTH, inc), instantiated twice under the macro.

Test Plan:
- Branch at IF with pred 1, no stall -> corrected_en=1, result=1 same cycle; two edges later br_ex=1, pred_ex=1.
- EX resolves taken=1 with pred_ex=1 -> mispredict=0, no rollback, no push.
- EX pred_ex=0, taken=1, br_id=1, pc_ex=0x100, target=0x200 -> same cycle:
  - mispredict=1, rollback_en_ex=1, rollback_en_id=1, redirect_pc=0x200, corrected_en=0
  - next cycle: corrected_en=1, result=1, fix_stall=1
  - following cycle: IDLE
- Same mispredict with taken=0, pred=1, pc_ex=0xFFFFFFFC -> redirect_pc=0x00000000 (wrap); rollback_en_id=0 when br_id=0.
- PL_stall=1 held 3 cycles with a branch at IF and a resolvable EX branch -> no corrected_en, no mispredict, slots unchanged; the resolve fires on the first unstalled cycle only.
- With BRU_PERF_COUNTER_EN and PERF_CNT_WIDTH=2: 5 resolves including 4 mispredicts -> perf_branches=3 and perf_mispredicts=3 (saturated); rst_n low mid-FIX -> all zero, no push after release.

Source files
------------

// File: rtl/branch_res_pkg.sv
// branch_res_pkg: shared types and constants for branch_resolution_unit and its counters.
package branch_res_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FIX  = 1'b1
    } state_t;

    localparam int unsigned PC_STEP  = 4;
    localparam logic        SAT_FILL = 1'b1;

endpackage

// File: rtl/sat_event_counter.sv
// sat_event_counter: event counter that sticks at all-ones instead of wrapping.
module sat_event_counter
    import branch_res_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic             w_full;

    assign w_full  = (r_count == {WIDTH{SAT_FILL}});
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (inc && !w_full)
            r_count <= r_count + WIDTH'(1);
    end

endmodule

// File: rtl/branch_resolution_unit.sv
// branch_resolution_unit: speculative history push at IF, EX-stage resolve, rollback and FIX re-push.
// Optional saturating statistics counters are built only with BRU_PERF_COUNTER_EN defined.
module branch_resolution_unit
    import branch_res_pkg::*;
#(
    parameter int PC_WIDTH       = 32,
    parameter int PERF_CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      PL_stall,
    input  logic                      if_is_branch,
    input  logic                      if_pred_taken,
    input  logic                      ex_resolve_en,
    input  logic                      ex_taken,
    input  logic [PC_WIDTH-1:0]       pc_ex,
    input  logic [PC_WIDTH-1:0]       ex_target,
    output logic                      corrected_en,
    output logic                      corrected_result,
    output logic                      rollback_en_id,
    output logic                      rollback_en_ex,
    output logic                      mispredict,
    output logic [PC_WIDTH-1:0]       redirect_pc,
    output logic                      fix_stall,
    output logic [PERF_CNT_WIDTH-1:0] perf_branches,
    output logic [PERF_CNT_WIDTH-1:0] perf_mispredicts
);

    state_t r_state, w_state_nxt;
    logic   r_br_id, r_pred_id, r_br_ex, r_pred_ex, r_fix_result;
    logic   w_res, w_mispredict, w_if_fire, w_in_fix;

    assign w_in_fix     = (r_state == FIX);
    assign w_res        = ex_resolve_en & r_br_ex & !PL_stall;
    assign w_mispredict = w_res & (ex_taken != r_pred_ex);
    assign w_if_fire    = if_is_branch & !PL_stall & !w_mispredict & !w_in_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FIX lasts exactly one cycle, independent of PL_stall
    always_comb begin
        w_state_nxt      = w_mispredict ? FIX : IDLE;
        corrected_en     = w_in_fix | w_if_fire;
        corrected_result = w_in_fix ? r_fix_result : (w_if_fire & if_pred_taken);
        fix_stall        = w_in_fix;
        mispredict       = w_mispredict;
        rollback_en_ex   = w_mispredict;
        rollback_en_id   = w_mispredict & r_br_id;
        redirect_pc      = !w_mispredict ? '0 :
                           ex_taken      ? ex_target : pc_ex + PC_WIDTH'(PC_STEP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_id      <= 1'b0;
            r_pred_id    <= 1'b0;
            r_br_ex      <= 1'b0;
            r_pred_ex    <= 1'b0;
            r_fix_result <= 1'b0;
        end else if (w_mispredict) begin
            r_br_id      <= 1'b0;
            r_br_ex      <= 1'b0;
            r_fix_result <= ex_taken;
        end else if (!PL_stall) begin
            r_br_ex      <= r_br_id;
            r_pred_ex    <= r_pred_id;
            r_br_id      <= w_if_fire;
            r_pred_id    <= if_pred_taken;
        end
    end

`ifdef BRU_PERF_COUNTER_EN
    sat_event_counter #(.WIDTH(PERF_CNT_WIDTH)) u_cnt_branches (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (w_res),
        .o_count (perf_branches)
    );

    sat_event_counter #(.WIDTH(PERF_CNT_WIDTH)) u_cnt_mispredicts (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (w_mispredict),
        .o_count (perf_mispredicts)
    );
`else
    assign perf_branches    = '0;
    assign perf_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// tb_branch_resolution_unit: directed scoreboard bench for branch_resolution_unit (perf width 2).
module tb_branch_resolution_unit;

    logic        clk = 1'b0;
    logic        rst_n, PL_stall, if_is_branch, if_pred_taken, ex_resolve_en, ex_taken;
    logic [31:0] pc_ex, ex_target, redirect_pc;
    logic        corrected_en, corrected_result, rollback_en_id, rollback_en_ex, mispredict, fix_stall;
    logic [1:0]  perf_branches, perf_mispredicts;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic        ce, cr, rid, rex, mp, fs;
        logic [31:0] rpc;
        int          pb, pm;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    branch_resolution_unit #(.PC_WIDTH(32), .PERF_CNT_WIDTH(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .PL_stall         (PL_stall),
        .if_is_branch     (if_is_branch),
        .if_pred_taken    (if_pred_taken),
        .ex_resolve_en    (ex_resolve_en),
        .ex_taken         (ex_taken),
        .pc_ex            (pc_ex),
        .ex_target        (ex_target),
        .corrected_en     (corrected_en),
        .corrected_result (corrected_result),
        .rollback_en_id   (rollback_en_id),
        .rollback_en_ex   (rollback_en_ex),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .fix_stall        (fix_stall),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    // Expected counter value for n raw events on a 2-bit saturating counter
    function automatic int pv(input int n);
`ifdef BRU_PERF_COUNTER_EN
        return (n > 3) ? 3 : n;
`else
        return 0;
`endif
    endfunction

    task automatic cmp(input string tag, input string fld, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s.%s: observed=%0h expected=%0h", tag, fld, got, want);
        end
    endtask

    task automatic step(input string tag, input logic st, ib, pt, rv, tk,
                        input logic [31:0] pc, tg,
                        input logic ce, cr, rid, rex, mp, input logic [31:0] rpc, input logic fs,
                        input int pb, pm);
        exp_t e;
        PL_stall = st; if_is_branch = ib; if_pred_taken = pt;
        ex_resolve_en = rv; ex_taken = tk; pc_ex = pc; ex_target = tg;
        q.push_back('{tag, ce, cr, rid, rex, mp, fs, rpc, pv(pb), pv(pm)});
        @(negedge clk);
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.queue: observed=empty expected=entry", tag);
        end else begin
            e = q.pop_front();
            cmp(e.tag, "corrected_en", 32'(corrected_en), 32'(e.ce));
            cmp(e.tag, "corrected_result", 32'(corrected_result), 32'(e.cr));
            cmp(e.tag, "rollback_en_id", 32'(rollback_en_id), 32'(e.rid));
            cmp(e.tag, "rollback_en_ex", 32'(rollback_en_ex), 32'(e.rex));
            cmp(e.tag, "mispredict", 32'(mispredict), 32'(e.mp));
            cmp(e.tag, "redirect_pc", redirect_pc, e.rpc);
            cmp(e.tag, "fix_stall", 32'(fix_stall), 32'(e.fs));
            cmp(e.tag, "perf_branches", 32'(perf_branches), 32'(e.pb));
            cmp(e.tag, "perf_mispredicts", 32'(perf_mispredicts), 32'(e.pm));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; PL_stall = 0; if_is_branch = 0; if_pred_taken = 0;
        ex_resolve_en = 0; ex_taken = 0; pc_ex = '0; ex_target = '0;
        repeat (2) @(posedge clk);
        #1;
        //   tag          st ib pt rv tk  pc            tg             ce cr id ex mp rpc           fs pb pm
        step("reset",     0, 0, 0, 0, 0, 32'h0,        32'h0,         0, 0, 0, 0, 0, 32'h0,        0, 0, 0);
        rst_n = 1'b1;
        step("if_push",   0, 1, 1, 0, 0, 32'h0,        32'h0,         1, 1, 0, 0, 0, 32'h0,        0, 0, 0);
        step("idle1",     0, 0, 0, 0, 0, 32'h0,        32'h0,         0, 0, 0, 0, 0, 32'h0,        0, 0, 0);
        step("res_ok",    0, 0, 0, 1, 1, 32'h300,      32'h400,       0, 0, 0, 0, 0, 32'h0,        0, 0, 0);
        step("res_nobr",  0, 0, 0, 1, 0, 32'h300,      32'h400,       0, 0, 0, 0, 0, 32'h0,        0, 1, 0);
        step("push_p0",   0, 1, 0, 0, 0, 32'h0,        32'h0,         1, 0, 0, 0, 0, 32'h0,        0, 1, 0);
        step("push_p1",   0, 1, 1, 0, 0, 32'h0,        32'h0,         1, 1, 0, 0, 0, 32'h0,        0, 1, 0);
        step("mp_taken",  0, 1, 1, 1, 1, 32'h100,      32'h200,       0, 0, 1, 1, 1, 32'h200,      0, 1, 0);
        step("fix1",      0, 1, 0, 0, 0, 32'h0,        32'h0,         1, 1, 0, 0, 0, 32'h0,        1, 2, 1);
        step("after_fix", 0, 1, 1, 0, 0, 32'h0,        32'h0,         1, 1, 0, 0, 0, 32'h0,        0, 2, 1);
        step("shift",     0, 0, 0, 0, 0, 32'h0,        32'h0,         0, 0, 0, 0, 0, 32'h0,        0, 2, 1);
        step("mp_wrap",   0, 0, 0, 1, 0, 32'hFFFFFFFC, 32'h1234,      0, 0, 0, 1, 1, 32'h0,        0, 2, 1);
        step("fix0_stall",1, 0, 0, 0, 0, 32'h0,        32'h0,         1, 0, 0, 0, 0, 32'h0,        1, 3, 2);
        step("push_s0",   0, 1, 0, 0, 0, 32'h0,        32'h0,         1, 0, 0, 0, 0, 32'h0,        0, 3, 2);
        step("push_s1",   0, 1, 1, 0, 0, 32'h0,        32'h0,         1, 1, 0, 0, 0, 32'h0,        0, 3, 2);
        for (int i = 0; i < 3; i++)
            step("stall",   1, 1, 1, 1, 1, 32'h40,       32'h80,        0, 0, 0, 0, 0, 32'h0,        0, 3, 2);
        step("unstall",   0, 1, 1, 1, 1, 32'h40,       32'h80,        0, 0, 1, 1, 1, 32'h80,       0, 3, 2);
        step("fix_nores", 0, 0, 0, 1, 1, 32'h40,       32'h80,        1, 1, 0, 0, 0, 32'h0,        1, 4, 3);
        step("push_r",    0, 1, 1, 0, 0, 32'h0,        32'h0,         1, 1, 0, 0, 0, 32'h0,        0, 4, 3);
        step("shift_r",   0, 0, 0, 0, 0, 32'h0,        32'h0,         0, 0, 0, 0, 0, 32'h0,        0, 4, 3);
        step("mp_rst",    0, 0, 0, 1, 0, 32'h10,       32'h99,        0, 0, 0, 1, 1, 32'h14,       0, 4, 3);
        rst_n = 1'b0;
        #1;
        step("rst_fix",   0, 0, 0, 0, 0, 32'h0,        32'h0,         0, 0, 0, 0, 0, 32'h0,        0, 0, 0);
        rst_n = 1'b1;
        step("post_rst",  0, 0, 0, 0, 0, 32'h0,        32'h0,         0, 0, 0, 0, 0, 32'h0,        0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
